// File: rtl/game_sequencer_if.sv
// Handshake bundle between the game sequencer and the surrounding game logic.
// The master side drives frame timing and player inputs; the slave side is the sequencer.
interface game_sequencer_if;
    logic       frame_tick;
    logic       start_btn;
    logic       collision;
    logic       player_at_goal;
    logic [2:0] state;
    logic [1:0] lives;
    logic [2:0] level;
    logic [3:0] lane_step;
    logic       player_reset;

    modport master (
        output frame_tick, start_btn, collision, player_at_goal,
        input  state, lives, level, lane_step, player_reset
    );

    modport slave (
        input  frame_tick, start_btn, collision, player_at_goal,
        output state, lives, level, lane_step, player_reset
    );
endinterface

// File: rtl/game_sequencer.sv
// Game flow sequencer: lives, level and per-lane car step scheduling.
// Define ATTRACT_MODE_EN to let lanes run at level-0 speed while IDLE.
module game_sequencer #(
    parameter int unsigned LIVES_INIT = 3,
    parameter int unsigned HIT_FRAMES = 60,
    parameter int unsigned LANE0_DIV  = 6,
    parameter int unsigned LANE1_DIV  = 4,
    parameter int unsigned LANE2_DIV  = 5,
    parameter int unsigned LANE3_DIV  = 3,
    parameter int unsigned MAX_LEVEL  = 7
) (
    input logic             CLK,
    input logic             RST,
    game_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPlay = 3'd1,
        StHit  = 3'd2,
        StWin  = 3'd3,
        StOver = 3'd4
    } state_e;

    localparam logic [3:0][7:0] LANE_DIVS = {8'(LANE3_DIV), 8'(LANE2_DIV),
                                             8'(LANE1_DIV), 8'(LANE0_DIV)};

    state_e     state_q;
    logic [1:0] lives_q;
    logic [2:0] level_q;
    logic [3:0] lane_step_q;
    logic       player_reset_q;
    logic [7:0] lane_cnt_q [4];
    logic [7:0] hit_cnt_q;
    logic       start_q;

    logic       start_edge;
    logic [7:0] eff_div [4];
    logic [7:0] cnt_inc [4];
    logic [3:0] wrap;
`ifdef ATTRACT_MODE_EN
    logic [3:0] idle_wrap;
`endif

    always_comb begin
        start_edge = bus.start_btn & ~start_q;
        for (int n = 0; n < 4; n++) begin
            // Divisor floors at 1 once the level catches up with the base rate.
            eff_div[n] = (LANE_DIVS[n] > {5'd0, level_q}) ? LANE_DIVS[n] - {5'd0, level_q}
                                                          : 8'd1;
            cnt_inc[n] = lane_cnt_q[n] + 8'd1;
            // >= so counters left above a freshly lowered divisor step immediately.
            wrap[n]    = cnt_inc[n] >= eff_div[n];
        end
`ifdef ATTRACT_MODE_EN
        for (int n = 0; n < 4; n++) begin
            idle_wrap[n] = cnt_inc[n] >= LANE_DIVS[n];
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= StIdle;
            lives_q        <= '0;
            level_q        <= '0;
            lane_step_q    <= '0;
            player_reset_q <= 1'b0;
            hit_cnt_q      <= '0;
            start_q        <= 1'b1;
            for (int n = 0; n < 4; n++) lane_cnt_q[n] <= '0;
        end else begin
            start_q        <= bus.start_btn;
            lane_step_q    <= '0;
            player_reset_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        state_q        <= StPlay;
                        lives_q        <= 2'(LIVES_INIT);
                        level_q        <= '0;
                        hit_cnt_q      <= '0;
                        player_reset_q <= 1'b1;
                        for (int n = 0; n < 4; n++) lane_cnt_q[n] <= '0;
                    end
`ifdef ATTRACT_MODE_EN
                    else if (bus.frame_tick) begin
                        for (int n = 0; n < 4; n++) begin
                            lane_cnt_q[n]  <= idle_wrap[n] ? 8'd0 : cnt_inc[n];
                            lane_step_q[n] <= idle_wrap[n];
                        end
                    end
`endif
                end
                StPlay: begin
                    if (bus.frame_tick) begin
                        for (int n = 0; n < 4; n++) begin
                            lane_cnt_q[n]  <= wrap[n] ? 8'd0 : cnt_inc[n];
                            lane_step_q[n] <= wrap[n];
                        end
                        if (bus.collision) begin
                            state_q   <= StHit;
                            lives_q   <= lives_q - 2'd1;
                            hit_cnt_q <= '0;
                        end else if (bus.player_at_goal) begin
                            state_q <= StWin;
                        end
                    end
                end
                StHit: begin
                    if (bus.frame_tick) begin
                        if (hit_cnt_q + 8'd1 >= 8'(HIT_FRAMES)) begin
                            hit_cnt_q <= '0;
                            if (lives_q == 2'd0) begin
                                state_q <= StOver;
                            end else begin
                                state_q        <= StPlay;
                                player_reset_q <= 1'b1;
                            end
                        end else begin
                            hit_cnt_q <= hit_cnt_q + 8'd1;
                        end
                    end
                end
                StWin: begin
                    if (bus.frame_tick) begin
                        if (level_q < 3'(MAX_LEVEL)) level_q <= level_q + 3'd1;
                        player_reset_q <= 1'b1;
                        state_q        <= StPlay;
                    end
                end
                StOver: begin
                    if (start_edge) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.state        = state_q;
    assign bus.lives        = lives_q;
    assign bus.level        = level_q;
    assign bus.lane_step    = lane_step_q;
    assign bus.player_reset = player_reset_q;

endmodule
